// File: rtl/wish_bus_arb_n.sv
// rtl/wish_bus_arb_n.sv - N-master / M-slave Wishbone-style shared bus arbiter with decode and watchdog
module wish_bus_arb_n #(
    parameter int                  N_MST    = 2,
    parameter int                  N_SLV    = 3,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {32'h0001_0100, 32'h0001_0000, 32'h0000_0000},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_8000},
    parameter logic [15:0]         TIMEOUT  = 16'd256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_MST-1:0]      m_cyc,
    input  logic [N_MST-1:0]      m_we,
    input  logic [4*N_MST-1:0]    m_strb,
    input  logic [32*N_MST-1:0]   m_addr,
    input  logic [32*N_MST-1:0]   m_data_i,
    output logic [N_MST-1:0]      m_ack,
    output logic [N_MST-1:0]      m_err,
    output logic [32*N_MST-1:0]   m_data_o,
    output logic [N_SLV-1:0]      s_cyc,
    output logic                  s_we,
    output logic [3:0]            s_strb,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_data_o,
    input  logic [N_SLV-1:0]      s_ack,
    input  logic [32*N_SLV-1:0]   s_data_i,
    output logic                  busy
);

    localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DERR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [15:0]     wdog_q, wdog_d;

    logic [GW-1:0]   pick_g;
    logic [31:0]     pick_addr;
    logic [SW:0]     dec_res;
    logic            g_cyc;
    logic            sel_ack;
    logic            wd_fire;

    // Round-robin: first requester after the previous winner, wrapping around.
    // Scanning from the farthest offset down lets the nearest requester overwrite the pick.
    function automatic logic [GW-1:0] rr_pick(input logic [N_MST-1:0] req, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        int            cand;
        pick = '0;
        for (int i = N_MST; i >= 1; i--) begin
            cand = (int'(last) + i) % N_MST;
            if (req[cand]) begin
                pick = cand[GW-1:0];
            end
        end
        return pick;
    endfunction

    // Address decode: returns {hit, index}; lowest slave index wins on overlapping windows.
    function automatic logic [SW:0] addr_decode(input logic [31:0] addr);
        logic          hit;
        logic [SW-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                idx = i[SW-1:0];
            end
        end
        return {hit, idx};
    endfunction

    assign pick_g    = rr_pick(m_cyc, last_grant_q);
    assign pick_addr = m_addr[32*pick_g +: 32];
    assign dec_res   = addr_decode(pick_addr);
    assign g_cyc     = m_cyc[grant_q];
    assign sel_ack   = s_ack[sel_q];
    assign wd_fire   = (TIMEOUT != 16'd0) && (wdog_q == (TIMEOUT - 16'd1));

    // Next-state: grant and decode in IDLE, completion/abort/timeout in XFER, single error cycle in DERR.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        wdog_d       = wdog_q;
        case (state_q)
            ST_IDLE: begin
                wdog_d = 16'd0;
                if (|m_cyc) begin
                    grant_d = pick_g;
                    if (dec_res[SW]) begin
                        sel_d   = dec_res[SW-1:0];
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_DERR;
                    end
                end
            end
            ST_XFER: begin
                wdog_d = wdog_q + 16'd1;
                if (!g_cyc || sel_ack || wd_fire) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            ST_DERR: begin
                state_d      = ST_IDLE;
                last_grant_d = grant_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_MST - 1);
            sel_q        <= '0;
            wdog_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            wdog_q       <= wdog_d;
        end
    end

    // Bus routing: live master fields out, selected slave ack/data back; all zero outside XFER.
    always_comb begin
        m_ack    = '0;
        m_err    = '0;
        m_data_o = '0;
        s_cyc    = '0;
        s_we     = 1'b0;
        s_strb   = 4'd0;
        s_addr   = 32'd0;
        s_data_o = 32'd0;
        case (state_q)
            ST_XFER: begin
                s_we                      = m_we[grant_q];
                s_strb                    = m_strb[4*grant_q +: 4];
                s_addr                    = m_addr[32*grant_q +: 32];
                s_data_o                  = m_data_i[32*grant_q +: 32];
                m_data_o[32*grant_q +: 32] = s_data_i[32*sel_q +: 32];
                if (g_cyc) begin
                    s_cyc[sel_q]  = !(wd_fire && !sel_ack);
                    m_ack[grant_q] = sel_ack;
                    m_err[grant_q] = wd_fire && !sel_ack;
                end
            end
            ST_DERR: begin
                m_err[grant_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wish_bus_arb_n.sv
// tb/tb_wish_bus_arb_n.sv - table-driven and sequence checks for wish_bus_arb_n
module tb_wish_bus_arb_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_cyc, m_we, m_ack, m_err;
    logic [7:0]  m_strb;
    logic [63:0] m_addr, m_data_i, m_data_o;
    logic [2:0]  s_cyc, s_ack;
    logic        s_we, busy;
    logic [3:0]  s_strb;
    logic [31:0] s_addr, s_data_o;
    logic [95:0] s_data_i;

    logic [1:0]  nw_m_cyc, nw_m_ack, nw_m_err;
    logic [63:0] nw_m_data_o;
    logic [2:0]  nw_s_cyc;
    logic        nw_s_we, nw_busy;
    logic [3:0]  nw_s_strb;
    logic [31:0] nw_s_addr, nw_s_data_o;

    int checks = 0;
    int errors = 0;

    localparam logic [95:0] BG = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};

    always #5 clk = ~clk;

    wish_bus_arb_n #(.N_MST(2), .N_SLV(3), .TIMEOUT(16'd16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_we(m_we), .m_strb(m_strb), .m_addr(m_addr), .m_data_i(m_data_i),
        .m_ack(m_ack), .m_err(m_err), .m_data_o(m_data_o),
        .s_cyc(s_cyc), .s_we(s_we), .s_strb(s_strb), .s_addr(s_addr), .s_data_o(s_data_o),
        .s_ack(s_ack), .s_data_i(s_data_i), .busy(busy)
    );

    wish_bus_arb_n #(.N_MST(2), .N_SLV(3), .TIMEOUT(16'd0)) u_nowd (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(nw_m_cyc), .m_we(m_we), .m_strb(m_strb), .m_addr(m_addr), .m_data_i(m_data_i),
        .m_ack(nw_m_ack), .m_err(nw_m_err), .m_data_o(nw_m_data_o),
        .s_cyc(nw_s_cyc), .s_we(nw_s_we), .s_strb(nw_s_strb), .s_addr(nw_s_addr), .s_data_o(nw_s_data_o),
        .s_ack(s_ack), .s_data_i(s_data_i), .busy(nw_busy)
    );

    typedef struct {
        int          mst;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] rdata;
        int          slv;
        logic [2:0]  exp_scyc;
        logic        exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_master(input int mst, input logic we, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] data);
        m_we[mst]            = we;
        m_addr[32*mst +: 32] = addr;
        m_strb[4*mst +: 4]   = strb;
        m_data_i[32*mst +: 32] = data;
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 32'h0000_0100, 4'hF, 32'h0,    3, 32'hDEAD_BEEF, 0, 3'b001, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0001_0104, 4'b0011, 32'h1234, 1, 32'h0000_0000, 2, 3'b100, 1'b0};
        vecs[2] = '{0, 1'b0, 32'hF000_0000, 4'hF, 32'h0,    0, 32'h0,         0, 3'b000, 1'b1};
        vecs[3] = '{1, 1'b0, 32'h0001_0010, 4'hF, 32'h0,    0, 32'hCAFE_0001, 1, 3'b010, 1'b0};
        vecs[4] = '{0, 1'b1, 32'h0000_7FFC, 4'b1000, 32'hA5A5_5A5A, 2, 32'h0, 0, 3'b001, 1'b0};
        vecs[5] = '{1, 1'b0, 32'h0000_8000, 4'hF, 32'h0,    0, 32'h0,         0, 3'b000, 1'b1};
        vecs[6] = '{0, 1'b0, 32'h0001_01FF, 4'hF, 32'h0,    1, 32'h7777_8888, 2, 3'b100, 1'b0};

        rst_n = 1'b0; m_cyc = '0; nw_m_cyc = '0; m_we = '0; m_strb = '0;
        m_addr = '0; m_data_i = '0; s_ack = '0; s_data_i = BG;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_scyc", s_cyc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack_err", {m_ack, m_err}, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_mdata", m_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            vec_t v;
            int   om;
            v  = vecs[k];
            om = 1 - v.mst;
            @(negedge clk);
            s_data_i = BG;
            set_master(v.mst, v.we, v.addr, v.strb, v.wdata);
            m_cyc[v.mst] = 1'b1;
            @(negedge clk);
            #1;
            if (v.exp_err) begin
                chk("derr_err", m_err, 2'b01 << v.mst);
                chk("derr_scyc", s_cyc, 0);
                chk("derr_busy", busy, 1);
                chk("derr_ack", m_ack, 0);
                m_cyc = '0;
                @(negedge clk);
                #1;
                chk("derr_idle", {busy, m_err}, 0);
            end else begin
                chk("scyc", s_cyc, v.exp_scyc);
                chk("saddr", s_addr, v.addr);
                chk("swe", s_we, v.we);
                chk("sstrb", s_strb, v.strb);
                chk("sdata", s_data_o, v.wdata);
                for (int j = 0; j < v.ack_dly; j++) begin
                    s_ack = 3'b001 << ((v.slv + 1) % 3);
                    #1;
                    chk("foreign_ack", m_ack, 0);
                    @(negedge clk);
                    s_ack = '0;
                    #1;
                end
                s_data_i[32*v.slv +: 32] = v.rdata;
                s_ack = 3'b001 << v.slv;
                #1;
                chk("mack", m_ack, 2'b01 << v.mst);
                chk("mdata", m_data_o[32*v.mst +: 32], v.rdata);
                chk("mdata_other", m_data_o[32*om +: 32], 0);
                chk("merr", m_err, 0);
                @(negedge clk);
                s_ack = '0;
                m_cyc = '0;
                #1;
                chk("post_idle", {busy, s_cyc}, 0);
            end
        end

        // Round robin: both request together after reset, twice.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            s_data_i = BG;
            set_master(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
            set_master(1, 1'b0, 32'h0001_0000, 4'hF, 32'h0);
            m_cyc = 2'b11;
            @(negedge clk); #1;
            chk("rr_first_scyc", s_cyc, 3'b001);
            chk("rr_first_addr", s_addr, 32'h0000_0100);
            s_ack = 3'b001; #1;
            chk("rr_first_ack", m_ack, 2'b01);
            @(negedge clk);
            s_ack = '0; m_cyc[0] = 1'b0; #1;
            chk("rr_gap_idle", busy, 0);
            @(negedge clk); #1;
            chk("rr_second_scyc", s_cyc, 3'b010);
            chk("rr_second_addr", s_addr, 32'h0001_0000);
            s_ack = 3'b010; #1;
            chk("rr_second_ack", m_ack, 2'b10);
            chk("rr_second_data", m_data_o[63:32], 32'hBAD0_0001);
            @(negedge clk);
            s_ack = '0; m_cyc = '0;
        end

        // Watchdog: TIMEOUT=16 fires on 16th XFER cycle; TIMEOUT=0 keeps waiting.
        @(negedge clk);
        set_master(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        m_cyc = 2'b01; nw_m_cyc = 2'b01;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); #1;
            if (c < 16) begin
                chk("wd_wait_scyc", s_cyc, 3'b001);
                chk("wd_wait_err", m_err, 0);
            end else begin
                chk("wd_fire_err", m_err, 2'b01);
                chk("wd_fire_scyc", s_cyc, 0);
                chk("wd_fire_ack", m_ack, 0);
                chk("nowd_err", nw_m_err, 0);
                chk("nowd_scyc", nw_s_cyc, 3'b001);
            end
        end
        m_cyc = '0;
        @(negedge clk); #1;
        chk("wd_back_idle", busy, 0);
        chk("nowd_still_busy", nw_busy, 1);
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk); #1;
                if (nw_s_cyc !== 3'b001 || nw_m_err !== 2'b00) bad++;
            end
            chk("nowd_long_wait", bad, 0);
        end
        nw_m_cyc = '0;
        @(negedge clk); #1;
        chk("nowd_abort_idle", nw_busy, 0);

        // Abort by M0, then reset during M1 transfer.
        @(negedge clk);
        set_master(0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        m_cyc = 2'b01;
        @(negedge clk); #1;
        chk("abort_pre_scyc", s_cyc, 3'b001);
        @(negedge clk);
        m_cyc = '0; #1;
        chk("abort_scyc_drop", s_cyc, 0);
        chk("abort_no_resp", {m_ack, m_err}, 0);
        @(negedge clk); #1;
        chk("abort_idle", busy, 0);
        set_master(1, 1'b0, 32'h0001_0000, 4'hF, 32'h0);
        m_cyc = 2'b10;
        @(negedge clk); #1;
        chk("rstx_pre_scyc", s_cyc, 3'b010);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rstx_scyc", s_cyc, 0);
        chk("rstx_busy", busy, 0);
        chk("rstx_no_resp", {m_ack, m_err}, 0);
        m_cyc = '0; rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
